// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch controller: FSM state codes, redirect-source
// codes and the default address width.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_PEND  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  localparam logic [1:0] SRC_NONE   = 2'd0;
  localparam logic [1:0] SRC_TRAP   = 2'd1;
  localparam logic [1:0] SRC_BRANCH = 2'd2;
  localparam logic [1:0] SRC_JUMP   = 2'd3;

  function automatic logic src_is_branch_or_jump(input logic [1:0] src);
    return (src == SRC_BRANCH) || (src == SRC_JUMP);
  endfunction

endpackage

// File: rtl/fetch_ctrl_redirect_arb.sv
// Combinational fixed-priority redirect select: trap > branch > jump.
// Losing requests in the same cycle are simply not reported.
module redirect_arb
  import fetch_pkg::*;
#(
  parameter int XLEN = FETCH_XLEN
) (
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            branch_en,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_target,
  output logic            valid,
  output logic [1:0]      src,
  output logic [XLEN-1:0] target
);

  always_comb begin
    valid  = 1'b1;
    src    = SRC_TRAP;
    target = trap_vector;
    if (trap_en) begin
      src    = SRC_TRAP;
      target = trap_vector;
    end else if (branch_en) begin
      src    = SRC_BRANCH;
      target = branch_target;
    end else if (jump_en) begin
      src    = SRC_JUMP;
      target = jump_target;
    end else begin
      valid  = 1'b0;
      src    = SRC_NONE;
      target = '0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// PC sequencer: redirect arbitration, stall/backpressure hold, pending redirect and
// post-redirect flush bubbles. Optional FETCH_MISALIGN_TRAP_EN adds misaligned-target trapping.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int XLEN         = FETCH_XLEN,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] cur_pc,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            branch_en,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_target,
  input  logic            stall,
  input  logic            imem_ready,
  output logic            pc_load,
  output logic [XLEN-1:0] pc_target,
  output logic            flush_if,
  output logic            flush_id,
  output logic            fetch_valid,
  output logic [1:0]      state_o
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            misalign_exc,
  output logic [XLEN-1:0] misalign_addr
`endif
);

  localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

  logic [1:0]      state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;

  logic            bj_allow;
  logic            arb_valid;
  logic [1:0]      arb_src;
  logic [XLEN-1:0] arb_target;
  logic [XLEN-1:0] win_target;
  logic            win_flush_id;

  logic            load_c, flush_if_c, flush_id_c, fetch_valid_c;
  logic [XLEN-1:0] target_c;

  // Branch/jump requests seen while pending or flushing come from squashed slots.
  assign bj_allow = (state_q == ST_RUN) || (state_q == ST_HOLD);

  redirect_arb #(.XLEN(XLEN)) u_arb (
    .trap_en       (trap_en),
    .trap_vector   (trap_vector),
    .branch_en     (branch_en & bj_allow),
    .branch_target (branch_target),
    .jump_en       (jump_en & bj_allow),
    .jump_target   (jump_target),
    .valid         (arb_valid),
    .src           (arb_src),
    .target        (arb_target)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  logic            misalign;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

  assign misalign      = arb_valid && src_is_branch_or_jump(arb_src) && (arb_target[1:0] != 2'b00);
  assign win_target    = misalign ? trap_vector : arb_target;
  assign win_flush_id  = misalign || (arb_src != SRC_JUMP);
  assign misalign_addr_d = misalign ? arb_target : misalign_addr_q;
  assign misalign_exc  = reset & misalign;
  assign misalign_addr = misalign_addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_addr_q <= '0;
    end else begin
      misalign_addr_q <= misalign_addr_d;
    end
  end
`else
  assign win_target   = arb_target;
  assign win_flush_id = (arb_src != SRC_JUMP);
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pend_target_d = pend_target_q;
    load_c        = 1'b0;
    target_c      = '0;
    flush_if_c    = 1'b0;
    flush_id_c    = 1'b0;
    fetch_valid_c = 1'b0;

    if (state_q == ST_PEND) begin
      load_c = 1'b1;
      if (imem_ready) begin
        target_c   = trap_en ? trap_vector : pend_target_q;
        flush_if_c = 1'b1;
        flush_id_c = 1'b1;
        state_d    = ST_FLUSH;
        cnt_d      = FLUSH_LAST;
      end else begin
        target_c = cur_pc;
        if (trap_en) begin
          pend_target_d = trap_vector;
        end
      end
    end else if (arb_valid) begin
      load_c = 1'b1;
      if (imem_ready) begin
        target_c   = win_target;
        flush_if_c = 1'b1;
        flush_id_c = win_flush_id;
        state_d    = ST_FLUSH;
        cnt_d      = FLUSH_LAST;
      end else begin
        // Memory busy: keep refetching the current PC and remember where to go.
        target_c      = cur_pc;
        pend_target_d = win_target;
        state_d       = ST_PEND;
      end
    end else if (state_q == ST_FLUSH) begin
      flush_if_c = 1'b1;
      if (cnt_q == 2'd0) begin
        state_d = ST_RUN;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end else if ((state_q == ST_HOLD) || stall || !imem_ready) begin
      load_c   = 1'b1;
      target_c = cur_pc;
      state_d  = (stall || !imem_ready) ? ST_HOLD : ST_RUN;
    end else begin
      fetch_valid_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      cnt_q         <= 2'd0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_target_q <= pend_target_d;
    end
  end

  // Outputs are forced low while reset is held, independent of the inputs.
  assign pc_load     = reset & load_c;
  assign pc_target   = reset ? target_c : '0;
  assign flush_if    = reset & flush_if_c;
  assign flush_id    = reset & flush_id_c;
  assign fetch_valid = reset & fetch_valid_c;
  assign state_o     = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: table of per-cycle vectors fed through a
// scoreboard queue, plus hand-written reset and misalignment sequences.
module tb_fetch_ctrl;

  typedef struct packed {
    logic        ld;
    logic        fif;
    logic        fid;
    logic        fv;
    logic [1:0]  st;
    logic [31:0] tgt;
  } exp_t;

  typedef struct {
    logic [31:0] cur;
    logic        tr;
    logic [31:0] tv;
    logic        br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic        stl;
    logic        ir;
    exp_t        e;
  } vec_t;

  typedef struct {
    int   idx;
    exp_t e;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cur_pc, trap_vector, branch_target, jump_target;
  logic        trap_en, branch_en, jump_en, stall, imem_ready;
  logic        pc_load, flush_if, flush_id, fetch_valid;
  logic [31:0] pc_target;
  logic [1:0]  state_o;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_exc;
  logic [31:0] misalign_addr;
`endif

  vec_t tbl[$];
  sb_t  sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .cur_pc        (cur_pc),
    .trap_en       (trap_en),
    .trap_vector   (trap_vector),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .stall         (stall),
    .imem_ready    (imem_ready),
    .pc_load       (pc_load),
    .pc_target     (pc_target),
    .flush_if      (flush_if),
    .flush_id      (flush_id),
    .fetch_valid   (fetch_valid),
    .state_o       (state_o)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_exc  (misalign_exc),
    .misalign_addr (misalign_addr)
`endif
  );

  function automatic exp_t actual();
    return {pc_load, flush_if, flush_id, fetch_valid, state_o, pc_target};
  endfunction

  task automatic compare(input string name, input exp_t a, input exp_t e);
    n_checks++;
    if (a === e) begin
      n_pass++;
      $display("%s ok: ld=%0b tgt=%h fif=%0b fid=%0b fv=%0b st=%0d", name, a.ld, a.tgt, a.fif, a.fid, a.fv, a.st);
    end else begin
      $display("FAIL %s: got ld=%0b tgt=%h fif=%0b fid=%0b fv=%0b st=%0d, want ld=%0b tgt=%h fif=%0b fid=%0b fv=%0b st=%0d",
               name, a.ld, a.tgt, a.fif, a.fid, a.fv, a.st, e.ld, e.tgt, e.fif, e.fid, e.fv, e.st);
    end
  endtask

  task automatic check_bit(input string name, input logic a, input logic e);
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0b want %0b", name, a, e);
  endtask

  task automatic check_word(input string name, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h want %h", name, a, e);
  endtask

  // Scoreboard: pop one expectation per cycle, on the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_t s;
      s = sb_q.pop_front();
      compare($sformatf("vec%0d", s.idx), actual(), s.e);
    end
  end

  task automatic add(input logic [31:0] cur, input logic tr, input logic [31:0] tv,
                     input logic br, input logic [31:0] bt, input logic jp, input logic [31:0] jt,
                     input logic stl, input logic ir,
                     input logic ld, input logic [31:0] tgt, input logic fif, input logic fid,
                     input logic fv, input logic [1:0] st);
    vec_t v;
    v.cur = cur; v.tr = tr; v.tv = tv; v.br = br; v.bt = bt; v.jp = jp; v.jt = jt;
    v.stl = stl; v.ir = ir;
    v.e = '{ld: ld, fif: fif, fid: fid, fv: fv, st: st, tgt: tgt};
    tbl.push_back(v);
  endtask

  task automatic add_run(input logic [31:0] cur);
    add(cur, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0, 1, 2'd0);
  endtask

  task automatic add_flush(input logic [31:0] cur);
    add(cur, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h0, 1, 0, 0, 2'd3);
  endtask

  task automatic set_idle();
    cur_pc = 32'h0; trap_en = 0; trap_vector = 32'h0; branch_en = 0; branch_target = 32'h0;
    jump_en = 0; jump_target = 32'h0; stall = 0; imem_ready = 1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    sb_t s;
    @(posedge clk);
    #1;
    cur_pc = v.cur; trap_en = v.tr; trap_vector = v.tv; branch_en = v.br; branch_target = v.bt;
    jump_en = v.jp; jump_target = v.jt; stall = v.stl; imem_ready = v.ir;
    s.idx = idx;
    s.e   = v.e;
    sb_q.push_back(s);
  endtask

  initial begin
    vec_t v;
    reset = 1'b0;
    set_idle();
    branch_en = 1; branch_target = 32'h100;
    #2;
    compare("reset_state", actual(), '0);
    set_idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // 1: free run
    for (int i = 0; i < 10; i++) add_run(32'(i * 4));
    // 2: branch to 0x100, two flush cycles, back to RUN
    add(32'h28, 0, 32'h0, 1, 32'h100, 0, 32'h0, 0, 1, 1, 32'h100, 1, 1, 0, 2'd0);
    add_flush(32'h100); add_flush(32'h104); add_run(32'h108);
    // jump keeps ID/EX; branch inside FLUSH is ignored
    add(32'h10c, 0, 32'h0, 0, 32'h0, 1, 32'h200, 0, 1, 1, 32'h200, 1, 0, 0, 2'd0);
    add(32'h200, 0, 32'h0, 1, 32'h900, 0, 32'h0, 0, 1, 0, 32'h0, 1, 0, 0, 2'd3);
    add_flush(32'h204); add_run(32'h208);
    // 3: all three together -> trap; trap inside FLUSH redirects again
    add(32'h20c, 1, 32'h80, 1, 32'h300, 1, 32'h400, 0, 1, 1, 32'h80, 1, 1, 0, 2'd0);
    add(32'h80, 1, 32'h90, 0, 32'h0, 0, 32'h0, 0, 1, 1, 32'h90, 1, 1, 0, 2'd3);
    add_flush(32'h90); add_flush(32'h94); add_run(32'h98);
    // 4: jump to 0x40 while memory busy; branch in PEND ignored
    add(32'h50, 0, 32'h0, 0, 32'h0, 1, 32'h40, 0, 0, 1, 32'h50, 0, 0, 0, 2'd0);
    add(32'h50, 0, 32'h0, 1, 32'h500, 0, 32'h0, 0, 0, 1, 32'h50, 0, 0, 0, 2'd2);
    add(32'h50, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h50, 0, 0, 0, 2'd2);
    add(32'h50, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 1, 32'h40, 1, 1, 0, 2'd2);
    add_flush(32'h40); add_flush(32'h44); add_run(32'h48);
    // trap in PEND overwrites the pending jump
    add(32'h54, 0, 32'h0, 0, 32'h0, 1, 32'h60, 0, 0, 1, 32'h54, 0, 0, 0, 2'd0);
    add(32'h54, 1, 32'ha0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h54, 0, 0, 0, 2'd2);
    add(32'h54, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 1, 32'ha0, 1, 1, 0, 2'd2);
    add_flush(32'ha0); add_flush(32'ha4); add_run(32'ha8);
    // 5: stall at 0x20, branch in the second stall cycle wins
    add(32'h20, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 1, 1, 32'h20, 0, 0, 0, 2'd0);
    add(32'h20, 0, 32'h0, 1, 32'h120, 0, 32'h0, 1, 1, 1, 32'h120, 1, 1, 0, 2'd1);
    add(32'h120, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 1, 0, 32'h0, 1, 0, 0, 2'd3);
    add(32'h124, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 1, 0, 32'h0, 1, 0, 0, 2'd3);
    add_run(32'h128);
    // plain HOLD via stall, then via backpressure
    add(32'h30, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 1, 1, 32'h30, 0, 0, 0, 2'd0);
    add(32'h30, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 1, 1, 32'h30, 0, 0, 0, 2'd1);
    add(32'h30, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 1, 32'h30, 0, 0, 0, 2'd1);
    add_run(32'h30);
    add(32'h34, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h34, 0, 0, 0, 2'd0);
    add(32'h34, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 1, 32'h34, 0, 0, 0, 2'd1);
    add_run(32'h34);

    foreach (tbl[i]) apply(tbl[i], i);

    // 6: reset asserted while in PEND
    v = '{cur: 32'h10, tr: 0, tv: 32'h0, br: 0, bt: 32'h0, jp: 1, jt: 32'h70, stl: 0, ir: 0,
          e: '{ld: 1, fif: 0, fid: 0, fv: 0, st: 2'd0, tgt: 32'h10}};
    apply(v, 1000);
    v.jp = 0; v.e.st = 2'd2;
    apply(v, 1001);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 compare("async_reset_pend", actual(), '0);
    @(posedge clk);
    #2 set_idle();
    reset = 1'b1;
    v = '{cur: 32'h0, tr: 0, tv: 32'h0, br: 0, bt: 32'h0, jp: 0, jt: 32'h0, stl: 0, ir: 1,
          e: '{ld: 0, fif: 0, fid: 0, fv: 1, st: 2'd0, tgt: 32'h0}};
    apply(v, 1002);
    v.cur = 32'h4;
    apply(v, 1003);

`ifdef FETCH_MISALIGN_TRAP_EN
    v = '{cur: 32'h8, tr: 0, tv: 32'h80, br: 1, bt: 32'h102, jp: 0, jt: 32'h0, stl: 0, ir: 1,
          e: '{ld: 1, fif: 1, fid: 1, fv: 0, st: 2'd0, tgt: 32'h80}};
    apply(v, 1004);
    #2 check_bit("misalign_exc_pulse", misalign_exc, 1'b1);
    @(posedge clk);
    #1 check_word("misalign_addr", misalign_addr, 32'h102);
    check_bit("misalign_exc_clear", misalign_exc, 1'b0);
    set_idle();
    @(negedge clk);
`endif

    @(negedge clk);
    #2;
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
